// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and RAM-side signals of the memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              dbg_req;
   logic              data_req;
   logic              fetch_req;
   logic              dbg_we;
   logic              data_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [ADDR_W-1:0] data_addr;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] data_wdata;
   logic              dbg_gnt;
   logic              data_gnt;
   logic              fetch_gnt;
   logic              dbg_valid;
   logic              data_valid;
   logic              fetch_valid;
   logic [DATA_W-1:0] rdata;
   logic              ram_cs;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;

   // Arbiter side
   modport slave (
      input  dbg_req, data_req, fetch_req, dbg_we, data_we,
      input  dbg_addr, data_addr, fetch_addr, dbg_wdata, data_wdata, ram_rdata,
      output dbg_gnt, data_gnt, fetch_gnt, dbg_valid, data_valid, fetch_valid,
      output rdata, ram_cs, ram_we, ram_addr, ram_wdata, busy
   );

   // Requesters and RAM, seen from outside the arbiter
   modport master (
      output dbg_req, data_req, fetch_req, dbg_we, data_we,
      output dbg_addr, data_addr, fetch_addr, dbg_wdata, data_wdata, ram_rdata,
      input  dbg_gnt, data_gnt, fetch_gnt, dbg_valid, data_valid, fetch_valid,
      input  rdata, ram_cs, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises debug, data and fetch accesses onto one single-port RAM.
// One access in flight; priority dbg > data > fetch, with fetch promoted over data
// after FETCH_MAX consecutive losses to data.
module mem_arbiter #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned RAM_LAT   = 1,
   parameter int unsigned FETCH_MAX = 3
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;
   typedef enum logic [1:0] {WinNone, WinDbg, WinData, WinFetch} win_e;

   localparam logic [2:0] AgeMax   = 3'(FETCH_MAX);
   localparam logic [1:0] WaitInit = 2'(RAM_LAT - 1);

   state_e            state_q, state_d;
   win_e              win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [2:0]        fetch_age_q, fetch_age_d;
   logic              fetch_wins;

   // Next state: arbitration in idle, RAM latency countdown, fetch ageing
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      fetch_age_d = fetch_age_q;
      fetch_wins  = bus.fetch_req && (!bus.data_req || (fetch_age_q == AgeMax));
      unique case (state_q)
         StIdle: begin
            if (bus.dbg_req) begin
               win_d   = WinDbg;
               we_d    = bus.dbg_we;
               addr_d  = bus.dbg_addr;
               wdata_d = bus.dbg_wdata;
            end else if (fetch_wins) begin
               win_d   = WinFetch;
               we_d    = 1'b0;
               addr_d  = bus.fetch_addr;
               wdata_d = '0;
            end else if (bus.data_req) begin
               win_d   = WinData;
               we_d    = bus.data_we;
               addr_d  = bus.data_addr;
               wdata_d = bus.data_wdata;
            end else begin
               win_d   = WinNone;
            end
            if (win_d != WinNone) state_d = StAccess;
            // A withdrawn or served fetch restarts its age; a dbg win leaves it alone
            if (!bus.fetch_req || (win_d == WinFetch)) begin
               fetch_age_d = '0;
            end else if ((win_d == WinData) && (fetch_age_q != AgeMax)) begin
               fetch_age_d = fetch_age_q + 3'd1;
            end
         end
         StAccess: begin
            state_d = StWait;
            cnt_d   = WaitInit;
         end
         StWait: begin
            if (cnt_q == 2'd0) begin
               rdata_d = bus.ram_rdata;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         win_q       <= WinNone;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         fetch_age_q <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         fetch_age_q <= fetch_age_d;
      end
   end

   // Outputs decoded from registered state only
   assign bus.dbg_gnt     = (state_q == StAccess) && (win_q == WinDbg);
   assign bus.data_gnt    = (state_q == StAccess) && (win_q == WinData);
   assign bus.fetch_gnt   = (state_q == StAccess) && (win_q == WinFetch);
   assign bus.dbg_valid   = (state_q == StResp) && (win_q == WinDbg);
   assign bus.data_valid  = (state_q == StResp) && (win_q == WinData);
   assign bus.fetch_valid = (state_q == StResp) && (win_q == WinFetch);
   assign bus.ram_cs      = (state_q == StAccess);
   assign bus.ram_we      = (state_q == StAccess) && we_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_wdata   = wdata_q;
   assign bus.rdata       = rdata_q;
   assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbiter (priority, promotion, fixed latency).
module tb_mem_arbiter;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LAT_A  = 1;
   localparam int unsigned LAT_B  = 3;
   localparam int unsigned FMAX   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic              ld_a = 1'b0;
   logic              ld_b = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(LAT_A), .FETCH_MAX(FMAX)) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(LAT_B), .FETCH_MAX(FMAX)) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   logic [DATA_W-1:0] mem_a  [256];
   logic [DATA_W-1:0] mem_b  [256];
   logic [DATA_W-1:0] pipe_a [LAT_A];
   logic [DATA_W-1:0] pipe_b [LAT_B];
   logic [DATA_W-1:0] model_mem [16];

   // RAM A: read data valid LAT_A cycles after the select cycle
   always @(posedge clk) begin
      pipe_a[0] <= bus_a.ram_cs ? mem_a[bus_a.ram_addr] : 16'hDEAD;
      if (bus_a.ram_cs && bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
      else if (ld_a) mem_a[ld_addr] <= ld_data;
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
   end
   assign bus_a.ram_rdata = pipe_a[LAT_A-1];

   // RAM B: read data valid LAT_B cycles after the select cycle
   always @(posedge clk) begin
      pipe_b[0] <= bus_b.ram_cs ? mem_b[bus_b.ram_addr] : 16'hDEAD;
      if (bus_b.ram_cs && bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
      else if (ld_b) mem_b[ld_addr] <= ld_data;
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign bus_b.ram_rdata = pipe_b[LAT_B-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [7:0] a, input logic [15:0] d);
      ld_addr = a; ld_data = d; ld_a = 1'b1;
      tick();
      ld_a = 1'b0;
   endtask

   task automatic load_b(input logic [7:0] a, input logic [15:0] d);
      ld_addr = a; ld_data = d; ld_b = 1'b1;
      tick();
      ld_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({bus_a.dbg_gnt, bus_a.data_gnt, bus_a.fetch_gnt, bus_a.dbg_valid, bus_a.data_valid,
           bus_a.fetch_valid, bus_a.ram_cs, bus_a.ram_we, bus_a.busy} !== 9'b0) begin
         n_bad++; $display("FAIL reset_ctrl_a: got nonzero control outputs, expected all 0");
      end
      n_cmp++;
      if ({bus_a.ram_addr, bus_a.ram_wdata, bus_a.rdata} !== 40'h0) begin
         n_bad++; $display("FAIL reset_data_a: got %h expected 0",
                           {bus_a.ram_addr, bus_a.ram_wdata, bus_a.rdata});
      end
      n_cmp++;
      if ({bus_b.dbg_gnt, bus_b.data_gnt, bus_b.fetch_gnt, bus_b.dbg_valid, bus_b.data_valid,
           bus_b.fetch_valid, bus_b.ram_cs, bus_b.ram_we, bus_b.busy} !== 9'b0) begin
         n_bad++; $display("FAIL reset_ctrl_b: got nonzero control outputs, expected all 0");
      end
      n_cmp++;
      if ({bus_b.ram_addr, bus_b.ram_wdata, bus_b.rdata} !== 40'h0) begin
         n_bad++; $display("FAIL reset_data_b: got %h expected 0",
                           {bus_b.ram_addr, bus_b.ram_wdata, bus_b.rdata});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_fetch();
      load_a(8'h10, 16'hA55A);
      bus_a.fetch_addr = 8'h10;
      bus_a.fetch_req  = 1'b1;
      n_cmp++;
      if (bus_a.busy !== 1'b0) begin
         n_bad++; $display("FAIL sf_busy c=0: got %b expected 0", bus_a.busy);
      end
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_cmp++;
         if (bus_a.fetch_gnt !== (c == 1) || bus_a.ram_cs !== (c == 1)) begin
            n_bad++; $display("FAIL sf_gnt_cs c=%0d: got gnt=%b cs=%b expected %b", c,
                              bus_a.fetch_gnt, bus_a.ram_cs, c == 1);
         end
         n_cmp++;
         if (bus_a.fetch_valid !== (c == 3)) begin
            n_bad++; $display("FAIL sf_valid c=%0d: got %b expected %b", c,
                              bus_a.fetch_valid, c == 3);
         end
         n_cmp++;
         if (bus_a.busy !== (c >= 1 && c <= 3)) begin
            n_bad++; $display("FAIL sf_busy c=%0d: got %b expected %b", c, bus_a.busy,
                              c >= 1 && c <= 3);
         end
         if (c == 1) begin
            n_cmp++;
            if (bus_a.ram_addr !== 8'h10) begin
               n_bad++; $display("FAIL sf_addr: got %h expected 10", bus_a.ram_addr);
            end
            bus_a.fetch_req = 1'b0;
         end
         if (c == 3) begin
            n_cmp++;
            if (bus_a.rdata !== 16'hA55A) begin
               n_bad++; $display("FAIL sf_rdata: got %h expected a55a", bus_a.rdata);
            end
         end
      end
   endtask

   task automatic test_data_write_read();
      for (int ph = 0; ph < 2; ph++) begin
         bus_b.data_we    = (ph == 0);
         bus_b.data_addr  = 8'h2F;
         bus_b.data_wdata = 16'h1234;
         bus_b.data_req   = 1'b1;
         for (int c = 1; c <= 6; c++) begin
            tick();
            n_cmp++;
            if (bus_b.data_gnt !== (c == 1) || bus_b.ram_cs !== (c == 1)) begin
               n_bad++; $display("FAIL dwr_gnt ph=%0d c=%0d: got gnt=%b cs=%b", ph, c,
                                 bus_b.data_gnt, bus_b.ram_cs);
            end
            n_cmp++;
            if (bus_b.ram_we !== (c == 1 && ph == 0)) begin
               n_bad++; $display("FAIL dwr_we ph=%0d c=%0d: got %b expected %b", ph, c,
                                 bus_b.ram_we, c == 1 && ph == 0);
            end
            n_cmp++;
            if (bus_b.data_valid !== (c == LAT_B + 2) || bus_b.busy !== (c <= LAT_B + 2)) begin
               n_bad++; $display("FAIL dwr_valid ph=%0d c=%0d: got valid=%b busy=%b", ph, c,
                                 bus_b.data_valid, bus_b.busy);
            end
            if (c == 1) begin
               n_cmp++;
               if (bus_b.ram_addr !== 8'h2F || (ph == 0 && bus_b.ram_wdata !== 16'h1234)) begin
                  n_bad++; $display("FAIL dwr_bus ph=%0d: got addr=%h wdata=%h expected 2f/1234",
                                    ph, bus_b.ram_addr, bus_b.ram_wdata);
               end
               bus_b.data_req = 1'b0;
            end
            if (c == LAT_B + 2 && ph == 1) begin
               n_cmp++;
               if (bus_b.rdata !== 16'h1234) begin
                  n_bad++; $display("FAIL dwr_rdata: got %h expected 1234", bus_b.rdata);
               end
            end
         end
      end
   endtask

   task automatic test_all_three();
      int order [3];
      int n_g;
      int n_v;
      int id;
      n_g = 0;
      n_v = 0;
      for (int k = 0; k < 3; k++) order[k] = -1;
      load_b(8'h01, 16'hB001);
      load_b(8'h02, 16'hB002);
      load_b(8'h03, 16'hB003);
      bus_b.dbg_we = 1'b0; bus_b.data_we = 1'b0;
      bus_b.dbg_addr = 8'h01; bus_b.data_addr = 8'h02; bus_b.fetch_addr = 8'h03;
      bus_b.dbg_req = 1'b1; bus_b.data_req = 1'b1; bus_b.fetch_req = 1'b1;
      for (int c = 0; c < 60 && n_v < 3; c++) begin
         tick();
         if (bus_b.dbg_gnt || bus_b.data_gnt || bus_b.fetch_gnt) begin
            id = bus_b.dbg_gnt ? 0 : (bus_b.data_gnt ? 1 : 2);
            if (n_g < 3) order[n_g] = id;
            n_g++;
            n_cmp++;
            if (bus_b.ram_addr !== 8'(id + 1)) begin
               n_bad++; $display("FAIL a3_addr id=%0d: got %h expected %h", id,
                                 bus_b.ram_addr, 8'(id + 1));
            end
            if (id == 0) bus_b.dbg_req = 1'b0;
            else if (id == 1) bus_b.data_req = 1'b0;
            else bus_b.fetch_req = 1'b0;
         end
         if (bus_b.dbg_valid || bus_b.data_valid || bus_b.fetch_valid) begin
            id = bus_b.dbg_valid ? 0 : (bus_b.data_valid ? 1 : 2);
            n_v++;
            n_cmp++;
            if (bus_b.rdata !== (16'hB000 | 16'(id + 1))) begin
               n_bad++; $display("FAIL a3_rdata id=%0d: got %h expected %h", id, bus_b.rdata,
                                 16'hB000 | 16'(id + 1));
            end
         end
      end
      n_cmp++;
      if (n_v != 3) begin
         n_bad++; $display("FAIL a3_timeout: got %0d completions expected 3", n_v);
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (order[k] != k) begin
            n_bad++; $display("FAIL a3_order k=%0d: got %0d expected %0d", k, order[k], k);
         end
      end
      bus_b.dbg_req = 1'b0; bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_fetch_promotion();
      int  n_g;
      logic exp_f;
      n_g = 0;
      bus_b.data_we = 1'b0; bus_b.data_addr = 8'h40; bus_b.fetch_addr = 8'h41;
      bus_b.data_req = 1'b1; bus_b.fetch_req = 1'b1;
      for (int c = 0; c < 100 && n_g < 8; c++) begin
         tick();
         if (bus_b.data_gnt || bus_b.fetch_gnt) begin
            exp_f = ((n_g % (FMAX + 1)) == FMAX);
            n_cmp++;
            if (bus_b.fetch_gnt !== exp_f || bus_b.data_gnt !== !exp_f) begin
               n_bad++; $display("FAIL promo_win k=%0d: got fetch_gnt=%b expected %b", n_g,
                                 bus_b.fetch_gnt, exp_f);
            end
            if (bus_b.fetch_gnt) begin
               n_cmp++;
               if (dut_b.fetch_age_q !== 3'd0) begin
                  n_bad++; $display("FAIL promo_age: got %0d expected 0", dut_b.fetch_age_q);
               end
            end
            n_g++;
            if (n_g == 8) begin
               bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
            end
         end
      end
      n_cmp++;
      if (n_g != 8) begin
         n_bad++; $display("FAIL promo_timeout: got %0d grants expected 8", n_g);
      end
      bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
      for (int c = 0; c < 20 && bus_b.busy; c++) tick();
      n_cmp++;
      if (bus_b.busy !== 1'b0) begin
         n_bad++; $display("FAIL promo_idle: got busy=%b expected 0", bus_b.busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n_dv;
      n_dv = 0;
      load_b(8'h06, 16'hB006);
      bus_b.data_we = 1'b0; bus_b.data_addr = 8'h05; bus_b.fetch_addr = 8'h06;
      bus_b.data_req = 1'b1; bus_b.fetch_req = 1'b1;
      tick();
      n_cmp++;
      if (bus_b.data_gnt !== 1'b1) begin
         n_bad++; $display("FAIL rst_gnt: got data_gnt=%b expected 1", bus_b.data_gnt);
      end
      bus_b.data_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({bus_b.dbg_gnt, bus_b.data_gnt, bus_b.fetch_gnt, bus_b.dbg_valid, bus_b.data_valid,
           bus_b.fetch_valid, bus_b.ram_cs, bus_b.ram_we, bus_b.busy} !== 9'b0) begin
         n_bad++; $display("FAIL rst_ctrl: got nonzero control outputs, expected all 0");
      end
      n_cmp++;
      if ({bus_b.ram_addr, bus_b.ram_wdata, bus_b.rdata} !== 40'h0 ||
          dut_b.fetch_age_q !== 3'd0) begin
         n_bad++; $display("FAIL rst_data: got %h age=%0d expected 0",
                           {bus_b.ram_addr, bus_b.ram_wdata, bus_b.rdata}, dut_b.fetch_age_q);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bus_b.fetch_gnt !== 1'b1 || bus_b.data_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_fetch_gnt: got fetch_gnt=%b data_valid=%b expected 1/0",
                           bus_b.fetch_gnt, bus_b.data_valid);
      end
      bus_b.fetch_req = 1'b0;
      for (int c = 5; c <= 9; c++) begin
         tick();
         if (bus_b.data_valid) n_dv++;
         n_cmp++;
         if (bus_b.fetch_valid !== (c == 4 + LAT_B + 1)) begin
            n_bad++; $display("FAIL rst_fvalid c=%0d: got %b expected %b", c,
                              bus_b.fetch_valid, c == 4 + LAT_B + 1);
         end
         if (c == 4 + LAT_B + 1) begin
            n_cmp++;
            if (bus_b.rdata !== 16'hB006) begin
               n_bad++; $display("FAIL rst_rdata: got %h expected b006", bus_b.rdata);
            end
         end
      end
      n_cmp++;
      if (n_dv != 0) begin
         n_bad++; $display("FAIL rst_no_data_valid: got %0d pulses expected 0", n_dv);
      end
   endtask

   task automatic test_fetch_withdraw();
      int n_fg;
      n_fg = 0;
      bus_b.data_we = 1'b0; bus_b.data_addr = 8'h07; bus_b.fetch_addr = 8'h08;
      bus_b.data_req = 1'b1; bus_b.fetch_req = 1'b1;
      tick();
      n_cmp++;
      if (bus_b.data_gnt !== 1'b1 || bus_b.fetch_gnt !== 1'b0) begin
         n_bad++; $display("FAIL wd_gnt: got data=%b fetch=%b expected 1/0",
                           bus_b.data_gnt, bus_b.fetch_gnt);
      end
      bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         tick();
         if (bus_b.fetch_gnt) n_fg++;
      end
      n_cmp++;
      if (n_fg != 0) begin
         n_bad++; $display("FAIL wd_fetch_gnt: got %0d grants expected 0", n_fg);
      end
      n_cmp++;
      if (bus_b.busy !== 1'b0 || dut_b.fetch_age_q !== 3'd0) begin
         n_bad++; $display("FAIL wd_idle: got busy=%b age=%0d expected 0/0",
                           bus_b.busy, dut_b.fetch_age_q);
      end
   endtask

   task automatic test_random();
      int          age;
      int          free_cyc;
      int          gnt_cyc;
      int          val_cyc;
      int          n;
      logic [2:0]  w_vec;
      logic [2:0]  exp_g;
      logic [2:0]  exp_v;
      logic        we_e;
      logic [7:0]  a_e;
      logic [15:0] wd_e;
      logic [15:0] rd_e;
      logic [15:0] v;
      age = 0; free_cyc = 0; gnt_cyc = -1; val_cyc = -1;
      w_vec = 3'b000; we_e = 1'b0; a_e = '0; wd_e = '0; rd_e = '0;
      for (int i = 0; i < 16; i++) begin
         v = 16'($urandom);
         model_mem[i] = v;
         load_b(8'(i), v);
      end
      for (int c = 0; c < 3000; c++) begin
         // Model: an arbitration happens in every idle cycle
         if (c >= free_cyc) begin
            if (bus_b.dbg_req) w_vec = 3'b100;
            else if (bus_b.fetch_req && (!bus_b.data_req || age == FMAX)) w_vec = 3'b001;
            else if (bus_b.data_req) w_vec = 3'b010;
            else w_vec = 3'b000;
            if (!bus_b.fetch_req || w_vec == 3'b001) age = 0;
            else if (w_vec == 3'b010 && age < FMAX) age++;
            if (w_vec != 3'b000) begin
               we_e = (w_vec == 3'b100) ? bus_b.dbg_we :
                      (w_vec == 3'b010) ? bus_b.data_we : 1'b0;
               a_e  = (w_vec == 3'b100) ? bus_b.dbg_addr :
                      (w_vec == 3'b010) ? bus_b.data_addr : bus_b.fetch_addr;
               wd_e = (w_vec == 3'b100) ? bus_b.dbg_wdata : bus_b.data_wdata;
               if (we_e) model_mem[a_e[3:0]] = wd_e;
               else rd_e = model_mem[a_e[3:0]];
               gnt_cyc  = c + 1;
               val_cyc  = c + 2 + LAT_B;
               free_cyc = c + 3 + LAT_B;
            end else begin
               free_cyc = c + 1;
            end
         end
         tick();
         n = c + 1;
         exp_g = (n == gnt_cyc) ? w_vec : 3'b000;
         exp_v = (n == val_cyc) ? w_vec : 3'b000;
         n_cmp++;
         if ({bus_b.dbg_gnt, bus_b.data_gnt, bus_b.fetch_gnt} !== exp_g) begin
            n_bad++; $display("FAIL rnd_gnt n=%0d: got %b expected %b", n,
                              {bus_b.dbg_gnt, bus_b.data_gnt, bus_b.fetch_gnt}, exp_g);
         end
         n_cmp++;
         if ({bus_b.dbg_valid, bus_b.data_valid, bus_b.fetch_valid} !== exp_v) begin
            n_bad++; $display("FAIL rnd_valid n=%0d: got %b expected %b", n,
                              {bus_b.dbg_valid, bus_b.data_valid, bus_b.fetch_valid}, exp_v);
         end
         n_cmp++;
         if (bus_b.busy !== (n >= gnt_cyc && n <= val_cyc) || bus_b.ram_cs !== (n == gnt_cyc))
         begin
            n_bad++; $display("FAIL rnd_busy_cs n=%0d: got busy=%b cs=%b", n, bus_b.busy,
                              bus_b.ram_cs);
         end
         if (n == gnt_cyc) begin
            n_cmp++;
            if (bus_b.ram_we !== we_e || bus_b.ram_addr !== a_e ||
                (we_e && bus_b.ram_wdata !== wd_e)) begin
               n_bad++; $display("FAIL rnd_ram n=%0d: got we=%b a=%h wd=%h expected %b %h %h",
                                 n, bus_b.ram_we, bus_b.ram_addr, bus_b.ram_wdata,
                                 we_e, a_e, wd_e);
            end
         end
         if (n == val_cyc && !we_e) begin
            n_cmp++;
            if (bus_b.rdata !== rd_e) begin
               n_bad++; $display("FAIL rnd_rdata n=%0d: got %h expected %h", n,
                                 bus_b.rdata, rd_e);
            end
         end
         // Requesters hold until granted, occasionally withdraw
         if (bus_b.dbg_req && !bus_b.dbg_gnt) begin
            if ($urandom_range(0, 99) < 3) bus_b.dbg_req = 1'b0;
         end else if ($urandom_range(0, 99) < 5) begin
            bus_b.dbg_req   = 1'b1;
            bus_b.dbg_we    = 1'($urandom_range(0, 1));
            bus_b.dbg_addr  = 8'($urandom_range(0, 15));
            bus_b.dbg_wdata = 16'($urandom);
         end else begin
            bus_b.dbg_req = 1'b0;
         end
         if (bus_b.data_req && !bus_b.data_gnt) begin
            if ($urandom_range(0, 99) < 3) bus_b.data_req = 1'b0;
         end else if ($urandom_range(0, 99) < 35) begin
            bus_b.data_req   = 1'b1;
            bus_b.data_we    = 1'($urandom_range(0, 1));
            bus_b.data_addr  = 8'($urandom_range(0, 15));
            bus_b.data_wdata = 16'($urandom);
         end else begin
            bus_b.data_req = 1'b0;
         end
         if (bus_b.fetch_req && !bus_b.fetch_gnt) begin
            if ($urandom_range(0, 99) < 3) bus_b.fetch_req = 1'b0;
         end else if ($urandom_range(0, 99) < 40) begin
            bus_b.fetch_req  = 1'b1;
            bus_b.fetch_addr = 8'($urandom_range(0, 15));
         end else begin
            bus_b.fetch_req = 1'b0;
         end
      end
      bus_b.dbg_req = 1'b0; bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
      for (int c = 0; c < 20 && bus_b.busy; c++) tick();
   endtask

   initial begin
      bus_a.dbg_req = 1'b0; bus_a.data_req = 1'b0; bus_a.fetch_req = 1'b0;
      bus_a.dbg_we = 1'b0; bus_a.data_we = 1'b0;
      bus_a.dbg_addr = '0; bus_a.data_addr = '0; bus_a.fetch_addr = '0;
      bus_a.dbg_wdata = '0; bus_a.data_wdata = '0;
      bus_b.dbg_req = 1'b0; bus_b.data_req = 1'b0; bus_b.fetch_req = 1'b0;
      bus_b.dbg_we = 1'b0; bus_b.data_we = 1'b0;
      bus_b.dbg_addr = '0; bus_b.data_addr = '0; bus_b.fetch_addr = '0;
      bus_b.dbg_wdata = '0; bus_b.data_wdata = '0;
      test_reset();
      test_single_fetch();
      test_data_write_read();
      test_all_three();
      test_fetch_promotion();
      test_reset_mid_wait();
      test_fetch_withdraw();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
